// File: rtl/npu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | npu_seq : element-wise sequencer for the NPU8 datapath (ADD/MUL/RQT).     |
// | Optional macro NPU_SEQ_PERF_EN adds the PERF_CYC busy-cycle counter.      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module npu_seq #(
  parameter int ADR_W    = 10,
  parameter int PIPE_LAT = 4
) (
  input  logic             CLK,
  input  logic             RESET_X,
  input  logic             SOFT_RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [1:0]       MSEL_INPUTA_SEL,
  input  logic [1:0]       MSEL_INPUTB_SEL,
  input  logic [1:0]       MSEL_OUTPUTC_SEL,
  input  logic [ADR_W-1:0] M1POS,
  input  logic [ADR_W-1:0] M2POS,
  input  logic [ADR_W-1:0] M3POS,
  input  logic [ADR_W-1:0] M1SIZE,
  input  logic [ADR_W-1:0] M2SIZE,
  input  logic [ADR_W-1:0] M3SIZE,
  output logic [2:0]       MEM_RE,
  output logic [ADR_W-1:0] MEM_RADR_A,
  output logic [ADR_W-1:0] MEM_RADR_B,
  output logic             DP_VALID_IN,
  output logic [2:0]       MEM_WE,
  output logic [ADR_W-1:0] MEM_WADR,
  output logic             BUSY,
  output logic             FINISH,
  output logic             ERR
`ifdef NPU_SEQ_PERF_EN
  ,
  output logic [15:0]      PERF_CYC
`endif
);

  localparam logic [1:0] c_OP_RQT = 2'd2;
  localparam logic [1:0] c_OP_RSV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [2:0] f_bank(input logic [1:0] sel);
    case (sel)
      2'd1:    f_bank = 3'b001;
      2'd2:    f_bank = 3'b010;
      2'd3:    f_bank = 3'b100;
      default: f_bank = 3'b000;
    endcase
  endfunction

  function automatic logic [ADR_W-1:0] f_sel(input logic [1:0] sel, input logic [ADR_W-1:0] v1,
                                             input logic [ADR_W-1:0] v2, input logic [ADR_W-1:0] v3);
    case (sel)
      2'd1:    f_sel = v1;
      2'd2:    f_sel = v2;
      2'd3:    f_sel = v3;
      default: f_sel = '0;
    endcase
  endfunction

  state_t                r_state;
  logic [1:0]            r_op, r_sel_a, r_sel_b, r_sel_c;
  logic [ADR_W-1:0]      r_pos_a, r_pos_b, r_pos_c, r_size_a, r_size_b, r_n;
  logic [ADR_W-1:0]      r_cnt, r_idx_a, r_idx_b, r_wadr;
  logic [ADR_W-1:0]      r_radr_a, r_radr_b;
  logic [2:0]            r_re;
  logic                  r_dp_valid, r_busy, r_finish, r_err;
  logic [PIPE_LAT-1:0]   r_vpipe;

  logic [1:0]            w_op, w_sel_a, w_sel_b, w_sel_c;
  logic [ADR_W-1:0]      w_pos_a, w_pos_b, w_pos_c, w_size_a, w_size_b, w_n;
  logic [ADR_W-1:0]      w_nidx_a, w_nidx_b, w_radr_a, w_radr_b;
  logic [2:0]            w_re;
  logic                  w_use_b, w_err, w_last;
  logic [PIPE_LAT-1:0]   w_pipe_nxt;

  // In IDLE the live register inputs describe the job about to start; afterwards only the shadows count.
  always_comb begin
    w_op     = r_op;
    w_sel_a  = r_sel_a;
    w_sel_b  = r_sel_b;
    w_sel_c  = r_sel_c;
    w_pos_a  = r_pos_a;
    w_pos_b  = r_pos_b;
    w_pos_c  = r_pos_c;
    w_size_a = r_size_a;
    w_size_b = r_size_b;
    w_n      = r_n;
    w_nidx_a = (r_idx_a + 1'b1 == r_size_a) ? '0 : r_idx_a + 1'b1;
    w_nidx_b = (r_idx_b + 1'b1 == r_size_b) ? '0 : r_idx_b + 1'b1;
    if (r_state == S_IDLE) begin
      w_op     = OP;
      w_sel_a  = MSEL_INPUTA_SEL;
      w_sel_b  = MSEL_INPUTB_SEL;
      w_sel_c  = MSEL_OUTPUTC_SEL;
      w_pos_a  = f_sel(MSEL_INPUTA_SEL, M1POS, M2POS, M3POS);
      w_pos_b  = f_sel(MSEL_INPUTB_SEL, M1POS, M2POS, M3POS);
      w_pos_c  = f_sel(MSEL_OUTPUTC_SEL, M1POS, M2POS, M3POS);
      w_size_a = f_sel(MSEL_INPUTA_SEL, M1SIZE, M2SIZE, M3SIZE);
      w_size_b = f_sel(MSEL_INPUTB_SEL, M1SIZE, M2SIZE, M3SIZE);
      w_n      = f_sel(MSEL_OUTPUTC_SEL, M1SIZE, M2SIZE, M3SIZE);
      w_nidx_a = '0;
      w_nidx_b = '0;
    end
    w_use_b    = (w_op != c_OP_RQT) && (w_sel_b != 2'd0);
    w_err      = (w_op == c_OP_RSV) || (w_sel_c == 2'd0) ||
                 ((w_sel_a != 2'd0) && (w_size_a == '0)) || (w_use_b && (w_size_b == '0));
    w_re       = f_bank(w_sel_a) | (w_use_b ? f_bank(w_sel_b) : 3'b000);
    w_radr_a   = (w_sel_a != 2'd0) ? w_pos_a + w_nidx_a : '0;
    w_radr_b   = w_use_b ? w_pos_b + w_nidx_b : '0;
    w_last     = (r_cnt == r_n - 1'b1);
    w_pipe_nxt = (r_vpipe << 1) | PIPE_LAT'(r_dp_valid);
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      r_op <= '0; r_sel_a <= '0; r_sel_b <= '0; r_sel_c <= '0;
      r_pos_a <= '0; r_pos_b <= '0; r_pos_c <= '0;
      r_size_a <= '0; r_size_b <= '0; r_n <= '0;
    end else if (r_state == S_IDLE && START && !SOFT_RESET) begin
      r_op <= w_op; r_sel_a <= w_sel_a; r_sel_b <= w_sel_b; r_sel_c <= w_sel_c;
      r_pos_a <= w_pos_a; r_pos_b <= w_pos_b; r_pos_c <= w_pos_c;
      r_size_a <= w_size_a; r_size_b <= w_size_b; r_n <= w_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      r_state <= S_IDLE; r_busy <= 1'b0; r_finish <= 1'b0; r_err <= 1'b0;
      r_re <= '0; r_radr_a <= '0; r_radr_b <= '0; r_dp_valid <= 1'b0; r_vpipe <= '0;
      r_cnt <= '0; r_idx_a <= '0; r_idx_b <= '0; r_wadr <= '0;
    end else if (SOFT_RESET) begin
      r_state <= S_IDLE; r_busy <= 1'b0; r_finish <= 1'b0; r_err <= 1'b0;
      r_re <= '0; r_radr_a <= '0; r_radr_b <= '0; r_dp_valid <= 1'b0; r_vpipe <= '0;
      r_cnt <= '0; r_idx_a <= '0; r_idx_b <= '0; r_wadr <= '0;
    end else begin
      r_vpipe <= w_pipe_nxt;
      if (r_vpipe[PIPE_LAT-1]) r_wadr <= r_wadr + 1'b1;
      case (r_state)
        S_IDLE: if (START) begin
          r_err   <= w_err;
          r_cnt   <= '0;
          r_idx_a <= '0;
          r_idx_b <= '0;
          r_wadr  <= w_pos_c;
          if (w_err || w_n == '0) begin
            r_state  <= S_DONE;
            r_finish <= 1'b1;
          end else begin
            r_state    <= S_ISSUE;
            r_busy     <= 1'b1;
            r_dp_valid <= 1'b1;
            r_re       <= w_re;
            r_radr_a   <= w_radr_a;
            r_radr_b   <= w_radr_b;
          end
        end
        S_ISSUE: if (w_last) begin
          r_state    <= S_DRAIN;
          r_dp_valid <= 1'b0;
          r_re       <= '0;
          r_radr_a   <= '0;
          r_radr_b   <= '0;
        end else begin
          r_cnt    <= r_cnt + 1'b1;
          r_idx_a  <= w_nidx_a;
          r_idx_b  <= w_nidx_b;
          r_re     <= w_re;
          r_radr_a <= w_radr_a;
          r_radr_b <= w_radr_b;
        end
        S_DRAIN: if (w_pipe_nxt == '0) begin
          r_state  <= S_DONE;
          r_finish <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: begin
          r_finish <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef NPU_SEQ_PERF_EN
  logic [15:0] r_perf;

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      r_perf <= '0;
    end else if (SOFT_RESET) begin
      r_perf <= '0;
    end else if (r_state == S_IDLE && START) begin
      r_perf <= '0;
    end else if (r_busy && r_perf != 16'hFFFF) begin
      r_perf <= r_perf + 1'b1;
    end
  end

  assign PERF_CYC = r_perf;
`endif

  assign MEM_RE      = r_re;
  assign MEM_RADR_A  = r_radr_a;
  assign MEM_RADR_B  = r_radr_b;
  assign DP_VALID_IN = r_dp_valid;
  assign MEM_WE      = r_vpipe[PIPE_LAT-1] ? f_bank(r_sel_c) : 3'b000;
  assign MEM_WADR    = r_vpipe[PIPE_LAT-1] ? r_wadr : '0;
  assign BUSY        = r_busy;
  assign FINISH      = r_finish;
  assign ERR         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_npu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_npu_seq : self-checking bench for npu_seq with a cycle-tagged scoreboard|
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_npu_seq;
  localparam int ADR_W = 10;
  localparam int L     = 4;

  logic             CLK = 1'b0;
  logic             RESET_X, SOFT_RESET, START;
  logic [1:0]       OP, SA, SB, SC;
  logic [ADR_W-1:0] M1POS, M2POS, M3POS, M1SIZE, M2SIZE, M3SIZE;
  logic [2:0]       MEM_RE, MEM_WE;
  logic [ADR_W-1:0] MEM_RADR_A, MEM_RADR_B, MEM_WADR;
  logic             DP_VALID_IN, BUSY, FINISH, ERR;
`ifdef NPU_SEQ_PERF_EN
  logic [15:0]      PERF_CYC;
`endif

  npu_seq #(.ADR_W(ADR_W), .PIPE_LAT(L)) dut (
    .CLK(CLK), .RESET_X(RESET_X), .SOFT_RESET(SOFT_RESET), .START(START), .OP(OP),
    .MSEL_INPUTA_SEL(SA), .MSEL_INPUTB_SEL(SB), .MSEL_OUTPUTC_SEL(SC),
    .M1POS(M1POS), .M2POS(M2POS), .M3POS(M3POS),
    .M1SIZE(M1SIZE), .M2SIZE(M2SIZE), .M3SIZE(M3SIZE),
    .MEM_RE(MEM_RE), .MEM_RADR_A(MEM_RADR_A), .MEM_RADR_B(MEM_RADR_B),
    .DP_VALID_IN(DP_VALID_IN), .MEM_WE(MEM_WE), .MEM_WADR(MEM_WADR),
    .BUSY(BUSY), .FINISH(FINISH), .ERR(ERR)
`ifdef NPU_SEQ_PERF_EN
    , .PERF_CYC(PERF_CYC)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int pos[4];
  int size[4];

  typedef struct {
    int               cyc;
    logic [2:0]       en;
    logic [ADR_W-1:0] a;
    logic [ADR_W-1:0] b;
    logic             chk_b;
  } ev_t;
  typedef struct {
    int   cyc;
    logic err;
  } fin_t;

  ev_t  rdq[$];
  ev_t  wrq[$];
  fin_t fnq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] bank(input logic [1:0] s);
    return (s == 2'd0) ? 3'b000 : (3'b001 << (s - 2'd1));
  endfunction

  // Scoreboard side: every observed read, write and finish is matched against the queue head.
  always @(negedge CLK) begin
    ev_t  e;
    fin_t f;
    if (RESET_X === 1'b1) begin
      if (DP_VALID_IN !== 1'b0 || MEM_RE !== 3'b000) begin
        if (rdq.size() == 0) chk("rd_unexpected", {DP_VALID_IN, MEM_RE}, 0);
        else begin
          e = rdq.pop_front();
          chk("rd_cyc", cyc, e.cyc);
          chk("rd_valid", DP_VALID_IN, 1);
          chk("rd_re", MEM_RE, e.en);
          chk("rd_adr_a", MEM_RADR_A, e.a);
          if (e.chk_b) chk("rd_adr_b", MEM_RADR_B, e.b);
        end
      end
      if (MEM_WE !== 3'b000) begin
        if (wrq.size() == 0) chk("wr_unexpected", MEM_WE, 0);
        else begin
          e = wrq.pop_front();
          chk("wr_cyc", cyc, e.cyc);
          chk("wr_we", MEM_WE, e.en);
          chk("wr_adr", MEM_WADR, e.a);
        end
      end
      if (FINISH !== 1'b0) begin
        if (fnq.size() == 0) chk("fin_unexpected", FINISH, 0);
        else begin
          f = fnq.pop_front();
          chk("fin_cyc", cyc, f.cyc);
          chk("fin_err", ERR, f.err);
          chk("fin_busy", BUSY, 0);
        end
      end
    end
  end

  task automatic start_job(input logic [1:0] op, sa, sb, sc, output bit err, output int n);
    int t;
    bit ub;
    logic [ADR_W-1:0] a, b, w;
    @(negedge CLK);
    OP = op; SA = sa; SB = sb; SC = sc;
    M1POS = ADR_W'(pos[1]); M2POS = ADR_W'(pos[2]); M3POS = ADR_W'(pos[3]);
    M1SIZE = ADR_W'(size[1]); M2SIZE = ADR_W'(size[2]); M3SIZE = ADR_W'(size[3]);
    START = 1'b1;
    t   = cyc;
    ub  = (op != 2'd2) && (sb != 2'd0);
    n   = size[sc];
    err = (op == 2'd3) || (sc == 2'd0) || (sa != 2'd0 && size[sa] == 0) || (ub && size[sb] == 0);
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        a = (sa != 2'd0) ? ADR_W'(pos[sa] + i % size[sa]) : '0;
        b = ub ? ADR_W'(pos[sb] + i % size[sb]) : '0;
        w = ADR_W'(pos[sc] + i);
        rdq.push_back('{t + 1 + i, bank(sa) | (ub ? bank(sb) : 3'b000), a, b, ub});
        wrq.push_back('{t + 1 + i + L, bank(sc), w, '0, 1'b0});
      end
    end
    fnq.push_back('{(err || n == 0) ? t + 1 : t + n + L + 1, err});
    @(negedge CLK);
    START = 1'b0;
    OP = 2'd3; SA = 2'd0; SB = 2'd0; SC = 2'd0;
    M1POS = '1; M2POS = '1; M3POS = '1; M1SIZE = '0; M2SIZE = '0; M3SIZE = '0;
    chk("busy_after_start", BUSY, !(err || n == 0));
  endtask

  task automatic run_job(input logic [1:0] op, sa, sb, sc, input bit dup);
    bit err;
    int n;
    start_job(op, sa, sb, sc, err, n);
    if (dup) begin
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    for (int k = 0; k < 200 && fnq.size() != 0; k++) @(negedge CLK);
    chk("fin_pending", fnq.size(), 0);
    chk("rd_left", rdq.size(), 0);
    chk("wr_left", wrq.size(), 0);
    @(negedge CLK);
    chk("err_hold", ERR, err);
  endtask

  task automatic flush();
    rdq.delete();
    wrq.delete();
    fnq.delete();
  endtask

  initial begin
    bit err;
    int n;
    RESET_X = 1'b0; SOFT_RESET = 1'b0; START = 1'b0;
    OP = '0; SA = '0; SB = '0; SC = '0;
    M1POS = '0; M2POS = '0; M3POS = '0; M1SIZE = '0; M2SIZE = '0; M3SIZE = '0;
    repeat (3) @(negedge CLK);
    chk("rst_rd_outs", {MEM_RE, MEM_RADR_A, MEM_RADR_B, DP_VALID_IN}, 0);
    chk("rst_wr_outs", {MEM_WE, MEM_WADR, BUSY, FINISH, ERR}, 0);
    RESET_X = 1'b1;

    pos = '{0, 'h10, 'h20, 'h30}; size = '{0, 4, 4, 4};
    run_job(2'd0, 2'd1, 2'd2, 2'd3, 1'b0);
`ifdef NPU_SEQ_PERF_EN
    chk("perf_add", PERF_CYC, 4 + L);
`endif
    size = '{0, 3, 1, 3};
    run_job(2'd0, 2'd1, 2'd2, 2'd3, 1'b0);
    pos = '{0, 'h40, 'h50, 'h60}; size = '{0, 5, 7, 2};
    run_job(2'd2, 2'd1, 2'd3, 2'd2, 1'b0);
    pos = '{0, 'h3FF, 'h100, 'h3FE}; size = '{0, 2, 1, 3};
    run_job(2'd1, 2'd1, 2'd1, 2'd3, 1'b0);
    pos = '{0, 'h200, 'h80, 'h10}; size = '{0, 5, 2, 1};
    run_job(2'd1, 2'd0, 2'd2, 2'd1, 1'b0);

    size = '{0, 4, 4, 4};
    run_job(2'd3, 2'd1, 2'd2, 2'd3, 1'b0);
    size[3] = 0;
    run_job(2'd0, 2'd1, 2'd2, 2'd3, 1'b0);
    size[3] = 4;
    run_job(2'd0, 2'd1, 2'd2, 2'd0, 1'b0);
    size = '{0, 0, 3, 3};
    run_job(2'd0, 2'd1, 2'd2, 2'd3, 1'b0);
    size = '{0, 2, 0, 3};
    run_job(2'd2, 2'd1, 2'd2, 2'd3, 1'b0);

    pos = '{0, 'h10, 'h20, 'h30}; size = '{0, 4, 4, 6};
    run_job(2'd0, 2'd1, 2'd2, 2'd3, 1'b1);

    start_job(2'd0, 2'd1, 2'd2, 2'd3, err, n);
    repeat (3) @(negedge CLK);
    SOFT_RESET = 1'b1;
    @(negedge CLK);
    SOFT_RESET = 1'b0;
    chk("soft_rd_outs", {MEM_RE, MEM_RADR_A, MEM_RADR_B, DP_VALID_IN}, 0);
    chk("soft_wr_outs", {MEM_WE, MEM_WADR, BUSY, FINISH, ERR}, 0);
    flush();
    repeat (L + 2) @(negedge CLK);

    start_job(2'd0, 2'd1, 2'd2, 2'd3, err, n);
    repeat (4) @(negedge CLK);
    #2 RESET_X = 1'b0;
    #1;
    chk("arst_rd_outs", {MEM_RE, MEM_RADR_A, MEM_RADR_B, DP_VALID_IN}, 0);
    chk("arst_wr_outs", {MEM_WE, MEM_WADR, BUSY, FINISH, ERR}, 0);
    @(negedge CLK);
    RESET_X = 1'b1;
    flush();
    repeat (L + 2) @(negedge CLK);

    pos = '{0, 'h10, 'h20, 'h30}; size = '{0, 4, 4, 4};
    run_job(2'd0, 2'd1, 2'd2, 2'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timed out");
  end

endmodule
`default_nettype wire

// File: doc/npu_seq.md
Name: npu_seq

Overview:
Sequencer for the NPU8 element-wise datapath (ADD / MUL / RQT).
- On START, it walks the selected input banks and the output bank.
- It issues read addresses for operands A/B and tracks datapath latency with a valid shift pipe.
- It issues write enables/addresses for result C, then pulses FINISH back to the CPU interface.
- It sits between the register file (cpu_if) and the three local memory banks M1..M3 plus the arithmetic pipe.

Parameters:
ADR_W, 10, bank address / position / size width
PIPE_LAT, 4, cycles from operand read issue to result available at datapath output (>=1)

Ports:
CLK  in  1  clock
RESET_X  in  1  asynchronous active-low reset
SOFT_RESET  in  1  synchronous clear pulse, same effect as reset
START  in  1  single-cycle start pulse
OP  in  2  0:ADD 1:MUL 2:RQT 3:reserved
MSEL_INPUTA_SEL  in  2  0:M0 constant, 1..3: bank M1..M3
MSEL_INPUTB_SEL  in  2  same encoding, ignored for RQT
MSEL_OUTPUTC_SEL  in  2  1..3: output bank; 0 illegal
M1POS, M2POS, M3POS  in  ADR_W each  bank base address
M1SIZE, M2SIZE, M3SIZE  in  ADR_W each  element count
MEM_RE  out  3  read enable per bank, bit k-1 = Mk
MEM_RADR_A  out  ADR_W  operand A read address
MEM_RADR_B  out  ADR_W  operand B read address
DP_VALID_IN  out  1  operand valid to datapath, same cycle as MEM_RE
MEM_WE  out  3  write enable per bank
MEM_WADR  out  ADR_W  result write address
BUSY  out  1  high from the cycle after START until FINISH
FINISH  out  1  one-cycle completion pulse
ERR  out  1  sticky config error, cleared by next START

Behaviour:
- Reset and SOFT_RESET: every output is 0, FSM goes to IDLE, counters and valid pipe are cleared. Both take effect mid-run with no write completion.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on START, capture OP, selects, POS and SIZE into shadow registers. Register inputs are ignored after this.
  - N = size of the C bank.
  - Error if any of: OP==3, OUTPUTC_SEL==0, size of a used input bank == 0. On error: set ERR, go to DONE, no memory access.
  - N==0: go to DONE, no access, ERR=0.
  - Otherwise go to ISSUE.
- ISSUE: index i runs 0..N-1, one element per cycle, no bubbles.
  - A index = i mod SIZE_A (wrapping counter; size 1 = broadcast).
  - B index = i mod SIZE_B (same rule).
  - Address = POS + index, wrapped modulo 2^ADR_W.
  - MEM_RE is the OR of the bank bits for A and, unless RQT, B. A bank selected for both A and B sets a single bit.
  - A or B selecting M0: no read for that operand, its address output is 0.
  - DP_VALID_IN=1 each cycle. After i=N-1, go to DRAIN.
- Valid pipe: PIPE_LAT-deep shift register.
  - Element i is written at issue cycle + PIPE_LAT.
  - MEM_WADR = POSC + i, wrapping. MEM_WE bit of the C bank is asserted.
  - Write index has its own counter.
- DRAIN: wait until the pipe is empty, then go to DONE.
- DONE: FINISH=1 for exactly one cycle, BUSY=0 in that cycle, then go to IDLE.
- Timing: START at cycle t → first read at t+1, last read at t+N, last write at t+N+PIPE_LAT, FINISH at t+N+PIPE_LAT+1.
- START outside IDLE is ignored.
- C bank equal to an input bank is allowed. Read-before-write ordering is the datapath's concern.

Optional Feature:
NPU_SEQ_PERF_EN
- Defined: adds output PERF_CYC (16 bits) and an internal counter.
  - Counter cleared on accepted START, increments every cycle while BUSY, saturates at 16'hFFFF.
  - PERF_CYC holds the value after FINISH until the next START; reset value 0.
- Undefined: port and logic are absent.

Test Plan:
- Reset: RESET_X low mid-run → all outputs 0 immediately; after release, START runs cleanly.
- ADD: A=M1 (POS 0x10, SIZE 4), B=M2 (POS 0x20, SIZE 4), C=M3 (POS 0x30, SIZE 4), PIPE_LAT=4, START at t → reads 0x10..0x13 / 0x20..0x23 at t+1..t+4; writes 0x30..0x33 at t+5..t+8; FINISH at t+9.
- Broadcast: B=M2 SIZE 1, C SIZE 3 → RADR_B = POS2 on all 3 reads.
- RQT with A=M1, B=M3, C=M2 SIZE 2 → MEM_RE=3'b001 only.
- Wrap: C POS 0x3FE, SIZE 3 → WADR 0x3FE, 0x3FF, 0x000.
- Errors and empty run: OP=3 → ERR=1, FINISH at t+1, no RE/WE. N=0 → FINISH at t+1, ERR=0. START while BUSY → ignored, single FINISH.
